sw_state_poller: RTL and testbench

SW_STATE_POLLER -- requirements
Module: sw_state_poller

---
 rtl/sw_state_poller_if.sv | 19 +
 rtl/sw_state_poller.sv | 77 +++++++
 tb/tb_sw_state_poller.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/sw_state_poller_if.sv
// sw_state_poller_if: switch-PIO master bus and CPU-facing slave bus of the poller
interface sw_state_poller_if;
  logic [1:0]  m_address;
  logic        m_read;
  logic [31:0] m_readdata;
  logic [1:0]  s_address;
  logic        s_read;
  logic        s_write;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  modport master (
    output m_address, m_read, s_readdata,
    input  m_readdata, s_address, s_read, s_write, s_writedata
  );
  modport slave (
    input  m_address, m_read, s_readdata,
    output m_readdata, s_address, s_read, s_write, s_writedata
  );
endinterface

// File: rtl/sw_state_poller.sv
// sw_state_poller: polls a switch PIO over Avalon-MM, debounces it and exposes state/changed/mask registers with irq
module sw_state_poller #(
  parameter int WIDTH        = 3,
  parameter int POLL_DIV     = 50000,
  parameter int STABLE_COUNT = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  sw_state_poller_if.master  bus,
  output logic               irq
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, EVAL} st_t;
  localparam logic [23:0] RELOAD = 24'(POLL_DIV - 1);
  localparam logic [3:0]  STABLE = 4'(STABLE_COUNT);
  st_t st, st_nx;
  logic [23:0] timer;
  logic poll_req, same, commit;
  logic [WIDTH-1:0] sample, cand, state, changed, mask, cand_nx, set_bits, clr_bits;
  logic [3:0] cnt, cnt_nx;
  logic [31:0] rdata;
  logic unused;
  assign unused = ^{bus.s_read, bus.m_readdata[31:WIDTH], bus.s_writedata[31:WIDTH]};
  assign poll_req = timer == 24'd0;
  // free-running poll timer, one request every POLL_DIV cycles
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) timer <= RELOAD;
    else timer <= poll_req ? RELOAD : timer - 24'd1;
  // master FSM state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) st <= IDLE;
    else st <= st_nx;
  // master FSM next state; requests outside IDLE are simply dropped
  always_comb
    st_nx = (st == IDLE) ? (poll_req ? REQ : IDLE) :
            (st == REQ)  ? WAIT :
            (st == WAIT) ? EVAL : IDLE;
  // master FSM outputs: single-cycle read strobe to PIO data register
  always_comb begin
    bus.m_read    = st == REQ;
    bus.m_address = 2'd0;
  end
  // debounce evaluation, commit decision and register access decode
  always_comb begin
    same     = sample == cand;
    cand_nx  = same ? cand : sample;
    cnt_nx   = !same ? 4'd1 : (cnt == STABLE) ? cnt : cnt + 4'd1;
    commit   = st == EVAL && cnt_nx == STABLE && cand_nx != state;
    set_bits = commit ? state ^ cand_nx : '0;
    clr_bits = (bus.s_write && bus.s_address == 2'd1) ? bus.s_writedata[WIDTH-1:0] : '0;
    rdata    = (bus.s_address == 2'd0) ? 32'(state) :
               (bus.s_address == 2'd1) ? 32'(changed) :
               (bus.s_address == 2'd2) ? 32'(mask) : 32'({cand, cnt});
  end
  // sample capture, debounce state, committed state, change flags, mask, read data and irq
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sample         <= '0;
      cand           <= '0;
      cnt            <= '0;
      state          <= '0;
      changed        <= '0;
      mask           <= '0;
      bus.s_readdata <= '0;
      irq            <= 1'b0;
    end else begin
      if (st == WAIT) sample <= bus.m_readdata[WIDTH-1:0];
      if (st == EVAL) begin
        cand <= cand_nx;
        cnt  <= cnt_nx;
      end
      if (commit) state <= cand_nx;
      changed <= (changed & ~clr_bits) | set_bits;
      if (bus.s_write && bus.s_address == 2'd2) mask <= bus.s_writedata[WIDTH-1:0];
      bus.s_readdata <= rdata;
      irq            <= |(changed & mask);
    end
endmodule

// File: tb/tb_sw_state_poller.sv
// tb_sw_state_poller: directed table-driven bench for the switch state poller
module tb_sw_state_poller;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic irq;
  int pass = 0;
  int total = 0;
  sw_state_poller_if bus();
  sw_state_poller #(.WIDTH(3), .POLL_DIV(8), .STABLE_COUNT(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .irq(irq)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit          rst;
    logic [2:0]  sw;
    logic [31:0] r0;
    logic [31:0] r1;
    logic [31:0] r3;
  } vec_t;
  vec_t tbl[11];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_m_read", {31'd0, bus.m_read}, 32'd0);
    chk("rst_m_address", {30'd0, bus.m_address}, 32'd0);
    chk("rst_s_readdata", bus.s_readdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask
  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.s_address = a;
    @(posedge clk);
    @(negedge clk);
    v = bus.s_readdata;
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.s_address   = a;
    bus.s_writedata = d;
    bus.s_write     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.s_write = 1'b0;
  endtask
  task automatic wait_req();
    int n = 0;
    while (!bus.m_read && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("poll_seen", {31'd0, bus.m_read}, 32'd1);
    chk("poll_addr", {30'd0, bus.m_address}, 32'd0);
  endtask
  task automatic poll(input logic [2:0] sw, input bit w1c);
    wait_req();
    bus.m_readdata = {29'h0ABCDEF, sw};
    @(posedge clk);
    @(posedge clk);
    if (w1c) begin
      @(negedge clk);
      bus.s_address   = 2'd1;
      bus.s_writedata = 32'd7;
      bus.s_write     = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    bus.s_write = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] v;
    int n;
    tbl[0]  = '{1'b1, 3'd5, 32'd0, 32'd0, 32'h51};
    tbl[1]  = '{1'b0, 3'd5, 32'd0, 32'd0, 32'h52};
    tbl[2]  = '{1'b0, 3'd5, 32'd0, 32'd0, 32'h53};
    tbl[3]  = '{1'b0, 3'd5, 32'd5, 32'd5, 32'h54};
    tbl[4]  = '{1'b1, 3'd5, 32'd0, 32'd0, 32'h51};
    tbl[5]  = '{1'b0, 3'd5, 32'd0, 32'd0, 32'h52};
    tbl[6]  = '{1'b0, 3'd2, 32'd0, 32'd0, 32'h21};
    tbl[7]  = '{1'b0, 3'd5, 32'd0, 32'd0, 32'h51};
    tbl[8]  = '{1'b0, 3'd5, 32'd0, 32'd0, 32'h52};
    tbl[9]  = '{1'b0, 3'd5, 32'd0, 32'd0, 32'h53};
    tbl[10] = '{1'b0, 3'd5, 32'd5, 32'd5, 32'h54};
    bus.m_readdata  = 32'd0;
    bus.s_address   = 2'd0;
    bus.s_read      = 1'b0;
    bus.s_write     = 1'b0;
    bus.s_writedata = 32'd0;
    @(negedge clk);
    do_reset();
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      chk($sformatf("period_m_read_%0d", i), {31'd0, bus.m_read}, {31'd0, i % 8 == 0});
      chk($sformatf("period_m_addr_%0d", i), {30'd0, bus.m_address}, 32'd0);
    end
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rst) do_reset();
      poll(tbl[i].sw, 1'b0);
      rd(2'd0, v);
      chk($sformatf("vec%0d_state", i), v, tbl[i].r0);
      rd(2'd1, v);
      chk($sformatf("vec%0d_changed", i), v, tbl[i].r1);
      rd(2'd3, v);
      chk($sformatf("vec%0d_cand_cnt", i), v, tbl[i].r3);
    end
    do_reset();
    wr(2'd2, 32'hFFFF_FFF9);
    rd(2'd2, v);
    chk("mask_rw", v, 32'd1);
    chk("irq_idle", {31'd0, irq}, 32'd0);
    repeat (4) poll(3'd5, 1'b0);
    chk("irq_lag", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_rise", {31'd0, irq}, 32'd1);
    wr(2'd1, 32'd1);
    chk("irq_hold", {31'd0, irq}, 32'd1);
    @(negedge clk);
    chk("irq_fall", {31'd0, irq}, 32'd0);
    rd(2'd1, v);
    chk("w1c_changed", v, 32'd4);
    do_reset();
    repeat (3) poll(3'd5, 1'b0);
    poll(3'd5, 1'b1);
    rd(2'd1, v);
    chk("w1c_set_wins", v, 32'd5);
    rd(2'd0, v);
    chk("w1c_state", v, 32'd5);
    do_reset();
    repeat (3) poll(3'd5, 1'b0);
    rd(2'd3, v);
    chk("pre_abort_cand_cnt", v, 32'h53);
    wait_req();
    bus.m_readdata = {29'h0ABCDEF, 3'd5};
    @(posedge clk);
    @(negedge clk);
    chk("pre_abort_readdata", bus.s_readdata, 32'h53);
    do_reset();
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (bus.m_read) break;
    end
    chk("first_read_after_abort", n, 32'd8);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rd(2'd0, v);
    chk("abort_state", v, 32'd0);
    rd(2'd1, v);
    chk("abort_changed", v, 32'd0);
    rd(2'd3, v);
    chk("abort_cand_cnt", v, 32'h51);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
